// File: rtl/ex_muldiv_if.sv
// ---------------------------------------------------------------------------
// ex_muldiv_if
// Request/result bundle between the EX stage and the iterative RV32M
// multiply/divide unit.
//   master : the EX stage issuing M-extension requests and consuming results
//   slave  : the multiply/divide unit itself
// Signals:
//   ID_md_vld / ID_md_op / ID_rd   request valid, funct3, destination
//   OF_x_rs1 / OF_x_rs2            forwarded operands
//   EX_flush                       abort current or incoming operation
//   MD_busy                        unit occupied, upstream must stall
//   MD_rd / MD_x_rd / MD_x_rd_vld  result destination, value, one-cycle valid
// ---------------------------------------------------------------------------
interface ex_muldiv_if;
  logic        ID_md_vld;
  logic [2:0]  ID_md_op;
  logic [4:0]  ID_rd;
  logic [31:0] OF_x_rs1;
  logic [31:0] OF_x_rs2;
  logic        EX_flush;
  logic        MD_busy;
  logic [4:0]  MD_rd;
  logic [31:0] MD_x_rd;
  logic        MD_x_rd_vld;

  modport master (
    output ID_md_vld, ID_md_op, ID_rd, OF_x_rs1, OF_x_rs2, EX_flush,
    input  MD_busy, MD_rd, MD_x_rd, MD_x_rd_vld
  );

  modport slave (
    input  ID_md_vld, ID_md_op, ID_rd, OF_x_rs1, OF_x_rs2, EX_flush,
    output MD_busy, MD_rd, MD_x_rd, MD_x_rd_vld
  );
endinterface

// File: rtl/ex_muldiv.sv
// ---------------------------------------------------------------------------
// ex_muldiv
// Iterative RV32M multiply/divide unit for the EX stage. Multiplies with a
// 32-step shift-add and divides with a 32-step restoring algorithm, both on
// operand magnitudes, fixing up signs at the end. Divide-by-zero and signed
// overflow finish in one cycle. Produces a single-cycle result pulse.
// Ports:
//   clk  in   clock, rising edge
//   rst  in   synchronous active-high reset
//   md   ex_muldiv_if.slave  request / result bundle
// ---------------------------------------------------------------------------
module ex_muldiv (
  input  logic        clk,
  input  logic        rst,
  ex_muldiv_if.slave  md
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [5:0]  r_cnt;
  logic [2:0]  r_op;
  logic [4:0]  r_rd;
  logic [31:0] r_a;        // multiplicand magnitude
  logic [31:0] r_b;        // multiplier / divisor magnitude
  logic        r_sign_p;   // product / quotient sign
  logic        r_sign_r;   // remainder sign
  logic [63:0] r_acc;      // product accumulator
  logic [32:0] r_rem;      // partial remainder
  logic [31:0] r_quo;      // dividend shifting out MSB-first, quotient in LSB-first

  logic        r_vld;
  logic [4:0]  r_out_rd;
  logic [31:0] r_out_x;

  // -------------------------------------------------------------------------
  // Operand conditioning at accept time
  // -------------------------------------------------------------------------
  logic        w_accept;
  logic        w_signed_a;
  logic        w_signed_b;
  logic        w_sa;
  logic        w_sb;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic        w_div_zero;
  logic        w_div_ovf;
  logic        w_early;
  logic [31:0] w_early_val;

  assign w_accept   = (r_state == S_IDLE) && md.ID_md_vld && !md.EX_flush;

  // rs1 signed: MULH(001) MULHSU(010) DIV(100) REM(110)
  assign w_signed_a = (md.ID_md_op == 3'b001) || (md.ID_md_op == 3'b010) ||
                      (md.ID_md_op == 3'b100) || (md.ID_md_op == 3'b110);
  // rs2 signed: MULH(001) DIV(100) REM(110)
  assign w_signed_b = (md.ID_md_op == 3'b001) ||
                      (md.ID_md_op == 3'b100) || (md.ID_md_op == 3'b110);

  assign w_sa    = w_signed_a && md.OF_x_rs1[31];
  assign w_sb    = w_signed_b && md.OF_x_rs2[31];
  assign w_mag_a = w_sa ? (~md.OF_x_rs1 + 32'd1) : md.OF_x_rs1;
  assign w_mag_b = w_sb ? (~md.OF_x_rs2 + 32'd1) : md.OF_x_rs2;

  // Divide special cases resolve straight from the raw operands.
  assign w_div_zero = (md.OF_x_rs2 == 32'd0);
  assign w_div_ovf  = !md.ID_md_op[0] &&
                      (md.OF_x_rs1 == 32'h8000_0000) &&
                      (md.OF_x_rs2 == 32'hFFFF_FFFF);
  assign w_early    = md.ID_md_op[2] && (w_div_zero || w_div_ovf);

  // op[1] selects remainder over quotient for the divide group.
  always_comb begin
    w_early_val = 32'd0;
    if (w_div_zero)
      w_early_val = md.ID_md_op[1] ? md.OF_x_rs1 : 32'hFFFF_FFFF;
    else
      w_early_val = md.ID_md_op[1] ? 32'd0 : 32'h8000_0000;
  end

  // -------------------------------------------------------------------------
  // Iteration datapath
  // -------------------------------------------------------------------------
  logic        w_last;
  logic [63:0] w_addend;
  logic [63:0] w_acc_next;
  logic [63:0] w_prod;
  logic [33:0] w_rem_shift;
  logic [33:0] w_trial;
  logic        w_q_bit;
  logic [32:0] w_rem_next;
  logic [31:0] w_quo_next;
  logic [31:0] w_quo_fix;
  logic [31:0] w_rem_fix;
  logic [31:0] w_mul_res;
  logic [31:0] w_div_res;
  logic [31:0] w_result;

  assign w_last = (r_cnt == 6'd31);

  // Multiply: add the multiplicand shifted by the current bit position.
  assign w_addend   = r_b[r_cnt[4:0]] ? ({32'd0, r_a} << r_cnt[4:0]) : 64'd0;
  assign w_acc_next = r_acc + w_addend;
  assign w_prod     = r_sign_p ? (~w_acc_next + 64'd1) : w_acc_next;
  assign w_mul_res  = (r_op[1:0] == 2'b00) ? w_prod[31:0] : w_prod[63:32];

  // Divide: bring in next dividend bit, trial-subtract, restore on borrow.
  assign w_rem_shift = {r_rem, r_quo[31]};
  assign w_trial     = w_rem_shift - {2'b00, r_b};
  assign w_q_bit     = !w_trial[33];
  assign w_rem_next  = w_q_bit ? w_trial[32:0] : w_rem_shift[32:0];
  assign w_quo_next  = {r_quo[30:0], w_q_bit};
  assign w_quo_fix   = r_sign_p ? (~w_quo_next + 32'd1) : w_quo_next;
  assign w_rem_fix   = r_sign_r ? (~w_rem_next[31:0] + 32'd1) : w_rem_next[31:0];
  assign w_div_res   = r_op[1] ? w_rem_fix : w_quo_fix;

  assign w_result    = r_op[2] ? w_div_res : w_mul_res;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_state_next;
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic (flush wins over everything but reset)
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (md.ID_md_vld) begin
          if (!md.ID_md_op[2])
            w_state_next = S_MUL;
          else if (w_early)
            w_state_next = S_DONE;
          else
            w_state_next = S_DIV;
        end
      end
      S_MUL:   if (w_last) w_state_next = S_DONE;
      S_DIV:   if (w_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    if (md.EX_flush)
      w_state_next = S_IDLE;
  end

  // -------------------------------------------------------------------------
  // FSM: outputs. Busy comes only from the state register; the valid pulse
  // is masked combinationally by a same-cycle flush.
  // -------------------------------------------------------------------------
  always_comb begin
    md.MD_busy     = (r_state != S_IDLE);
    md.MD_x_rd_vld = r_vld && !md.EX_flush;
    md.MD_rd       = r_out_rd;
    md.MD_x_rd     = r_out_x;
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= 6'd0;
      r_op     <= 3'd0;
      r_rd     <= 5'd0;
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_sign_p <= 1'b0;
      r_sign_r <= 1'b0;
      r_acc    <= 64'd0;
      r_rem    <= 33'd0;
      r_quo    <= 32'd0;
      r_vld    <= 1'b0;
      r_out_rd <= 5'd0;
      r_out_x  <= 32'd0;
    end else if (md.EX_flush) begin
      r_cnt <= 6'd0;
      r_vld <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= 6'd0;
          r_vld <= 1'b0;
          if (w_accept) begin
            r_op     <= md.ID_md_op;
            r_rd     <= md.ID_rd;
            r_a      <= w_mag_a;
            r_b      <= w_mag_b;
            r_sign_p <= w_sa ^ w_sb;
            r_sign_r <= w_sa;
            r_acc    <= 64'd0;
            r_rem    <= 33'd0;
            r_quo    <= w_mag_a;
            if (w_early) begin
              // x0 never carries a value or a valid.
              r_out_rd <= md.ID_rd;
              r_out_x  <= (md.ID_rd == 5'd0) ? 32'd0 : w_early_val;
              r_vld    <= (md.ID_rd != 5'd0);
            end
          end
        end
        S_MUL, S_DIV: begin
          if (r_state == S_MUL)
            r_acc <= w_acc_next;
          else begin
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
          end
          if (w_last) begin
            r_cnt    <= 6'd0;
            r_out_rd <= r_rd;
            r_out_x  <= (r_rd == 5'd0) ? 32'd0 : w_result;
            r_vld    <= (r_rd != 5'd0);
          end else begin
            r_cnt <= r_cnt + 6'd1;
          end
        end
        default: begin
          r_cnt <= 6'd0;
          r_vld <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
module tb_ex_muldiv;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  ex_muldiv_if md_if();

  ex_muldiv dut (
    .clk (clk),
    .rst (rst),
    .md  (md_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a request for exactly one cycle; returns at the negedge of N+1.
  task automatic issue(input logic [2:0] op, input logic [4:0] rd,
                       input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    md_if.ID_md_vld = 1'b1;
    md_if.ID_md_op  = op;
    md_if.ID_rd     = rd;
    md_if.OF_x_rs1  = a;
    md_if.OF_x_rs2  = b;
    @(negedge clk);
    md_if.ID_md_vld = 1'b0;
  endtask

  // Starting at N+1, step negedges until the pulse appears (bounded).
  task automatic wait_pulse(input int limit, output int k,
                            output logic [31:0] d, output logic [4:0] r);
    k = 1;
    while (!md_if.MD_x_rd_vld && k < limit) begin
      @(negedge clk);
      k++;
    end
    if (!md_if.MD_x_rd_vld) k = limit + 1;
    d = md_if.MD_x_rd;
    r = md_if.MD_rd;
  endtask

  // Count pulses over a window of cycles.
  task automatic count_pulses(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (md_if.MD_x_rd_vld) n++;
    end
  endtask

  task automatic test_reset;
    int n;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({md_if.MD_busy, md_if.MD_x_rd_vld, md_if.MD_rd, md_if.MD_x_rd} !== 39'd0) begin
      bad++;
      $display("FAIL reset_init: got busy=%b vld=%b rd=%0d x=%h want all 0",
               md_if.MD_busy, md_if.MD_x_rd_vld, md_if.MD_rd, md_if.MD_x_rd);
    end
    rst = 1'b0;
    // Reset mid-DIV
    issue(3'b101, 5'd4, 32'd1000, 32'd7);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({md_if.MD_busy, md_if.MD_x_rd_vld, md_if.MD_rd, md_if.MD_x_rd} !== 39'd0) begin
      bad++;
      $display("FAIL reset_mid_div: got busy=%b vld=%b rd=%0d x=%h want all 0",
               md_if.MD_busy, md_if.MD_x_rd_vld, md_if.MD_rd, md_if.MD_x_rd);
    end
    rst = 1'b0;
    count_pulses(40, n);
    total++;
    if (n !== 0) begin
      bad++;
      $display("FAIL reset_no_pulse: got %0d pulses want 0", n);
    end
    $display("reset: checked");
  endtask

  task automatic run_table(input string name, input int lat,
                           input logic [2:0] op, input logic [4:0] rd,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp);
    int k;
    logic [31:0] d;
    logic [4:0] r;
    issue(op, rd, a, b);
    total++;
    if (md_if.MD_busy !== 1'b1) begin
      bad++;
      $display("FAIL %s_busy: got %b want 1", name, md_if.MD_busy);
    end
    wait_pulse(40, k, d, r);
    total++;
    if (k !== lat || d !== exp || r !== rd) begin
      bad++;
      $display("FAIL %s: got lat=%0d x=%h rd=%0d want lat=%0d x=%h rd=%0d",
               name, k, d, r, lat, exp, rd);
    end
    @(negedge clk);
    total++;
    if (md_if.MD_x_rd_vld !== 1'b0 || md_if.MD_busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_after: got vld=%b busy=%b want 0 0",
               name, md_if.MD_x_rd_vld, md_if.MD_busy);
    end
    $display("%s: op=%b a=%h b=%h x=%h lat=%0d", name, op, a, b, d, k);
  endtask

  task automatic test_mul;
    run_table("mul",    33, 3'b000, 5'd5, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFA);
    run_table("mulh",   33, 3'b001, 5'd6, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run_table("mulhu",  33, 3'b011, 5'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_table("mulhsu", 33, 3'b010, 5'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
  endtask

  task automatic test_div;
    run_table("div",  33, 3'b100, 5'd9,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_table("rem",  33, 3'b110, 5'd10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run_table("divu", 33, 3'b101, 5'd11, 32'd100,       32'd7, 32'd14);
    run_table("remu", 33, 3'b111, 5'd12, 32'd100,       32'd7, 32'd2);
  endtask

  task automatic test_early;
    run_table("divu_z", 1, 3'b101, 5'd13, 32'd5,         32'd0,         32'hFFFF_FFFF);
    run_table("rem_z",  1, 3'b110, 5'd14, 32'd5,         32'd0,         32'd5);
    run_table("div_ov", 1, 3'b100, 5'd15, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_table("rem_ov", 1, 3'b110, 5'd16, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
  endtask

  task automatic test_flush;
    int n;
    // Flush at N+10 of a DIV
    issue(3'b100, 5'd17, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    md_if.EX_flush = 1'b1;
    @(negedge clk);
    md_if.EX_flush = 1'b0;
    total++;
    if (md_if.MD_busy !== 1'b0) begin
      bad++;
      $display("FAIL flush_mid_busy: got %b want 0", md_if.MD_busy);
    end
    count_pulses(40, n);
    total++;
    if (n !== 0) begin
      bad++;
      $display("FAIL flush_mid_pulse: got %0d pulses want 0", n);
    end
    // Flush in the DONE cycle (early-out lands DONE at N+1)
    issue(3'b101, 5'd3, 32'd5, 32'd0);
    md_if.EX_flush = 1'b1;
    #1;
    total++;
    if (md_if.MD_x_rd_vld !== 1'b0) begin
      bad++;
      $display("FAIL flush_done_mask: got vld=%b want 0", md_if.MD_x_rd_vld);
    end
    @(negedge clk);
    md_if.EX_flush = 1'b0;
    total++;
    if (md_if.MD_x_rd_vld !== 1'b0 || md_if.MD_busy !== 1'b0) begin
      bad++;
      $display("FAIL flush_done_after: got vld=%b busy=%b want 0 0",
               md_if.MD_x_rd_vld, md_if.MD_busy);
    end
    // Flush together with a request
    @(negedge clk);
    md_if.ID_md_vld = 1'b1;
    md_if.ID_md_op  = 3'b000;
    md_if.ID_rd     = 5'd18;
    md_if.OF_x_rs1  = 32'd3;
    md_if.OF_x_rs2  = 32'd4;
    md_if.EX_flush  = 1'b1;
    @(negedge clk);
    md_if.ID_md_vld = 1'b0;
    md_if.EX_flush  = 1'b0;
    total++;
    if (md_if.MD_busy !== 1'b0) begin
      bad++;
      $display("FAIL flush_accept_busy: got %b want 0", md_if.MD_busy);
    end
    count_pulses(40, n);
    total++;
    if (n !== 0) begin
      bad++;
      $display("FAIL flush_accept_pulse: got %0d pulses want 0", n);
    end
    $display("flush: checked");
  endtask

  task automatic test_x0;
    int errs;
    errs = 0;
    issue(3'b000, 5'd0, 32'd6, 32'd7);
    for (int k = 1; k <= 33; k++) begin
      if (md_if.MD_busy !== 1'b1 || md_if.MD_x_rd_vld !== 1'b0) errs++;
      @(negedge clk);
    end
    total++;
    if (errs !== 0) begin
      bad++;
      $display("FAIL x0_span: got %0d bad cycles want 0", errs);
    end
    total++;
    if (md_if.MD_busy !== 1'b0 || md_if.MD_x_rd_vld !== 1'b0) begin
      bad++;
      $display("FAIL x0_end: got busy=%b vld=%b want 0 0",
               md_if.MD_busy, md_if.MD_x_rd_vld);
    end
    $display("x0: bad cycles=%0d", errs);
  endtask

  task automatic test_back_to_back;
    int k;
    logic [31:0] d;
    logic [4:0] r;
    // First request MUL 6*7 -> rd7, then hold DIVU 100/7 -> rd9 continuously
    @(negedge clk);
    md_if.ID_md_vld = 1'b1;
    md_if.ID_md_op  = 3'b000;
    md_if.ID_rd     = 5'd7;
    md_if.OF_x_rs1  = 32'd6;
    md_if.OF_x_rs2  = 32'd7;
    @(negedge clk);
    md_if.ID_md_op  = 3'b101;
    md_if.ID_rd     = 5'd9;
    md_if.OF_x_rs1  = 32'd100;
    md_if.OF_x_rs2  = 32'd7;
    wait_pulse(40, k, d, r);
    total++;
    if (k !== 33 || d !== 32'd42 || r !== 5'd7) begin
      bad++;
      $display("FAIL b2b_first: got lat=%0d x=%h rd=%0d want lat=33 x=0000002a rd=7", k, d, r);
    end
    @(negedge clk);
    total++;
    if (md_if.MD_busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_idle: got busy=%b want 0", md_if.MD_busy);
    end
    @(negedge clk);
    md_if.ID_md_vld = 1'b0;
    total++;
    if (md_if.MD_busy !== 1'b1) begin
      bad++;
      $display("FAIL b2b_accept: got busy=%b want 1", md_if.MD_busy);
    end
    wait_pulse(40, k, d, r);
    total++;
    if (k !== 33 || d !== 32'd14 || r !== 5'd9) begin
      bad++;
      $display("FAIL b2b_second: got lat=%0d x=%h rd=%0d want lat=33 x=0000000e rd=9", k, d, r);
    end
    @(negedge clk);
    $display("back_to_back: second x=%h lat=%0d", d, k);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    md_if.ID_md_vld = 1'b0;
    md_if.ID_md_op  = 3'b000;
    md_if.ID_rd     = 5'd0;
    md_if.OF_x_rs1  = 32'd0;
    md_if.OF_x_rs2  = 32'd0;
    md_if.EX_flush  = 1'b0;
    test_reset;
    test_mul;
    test_div;
    test_early;
    test_flush;
    test_x0;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative RV32M multiply/divide unit in the EX stage, directly downstream of operand forwarding. It consumes the forwarded operands `OF_x_rs1`/`OF_x_rs2` for M-extension instructions and computes them over multiple cycles. While it works it holds the pipeline via `MD_busy`. It returns a single-cycle result pulse (`MD_rd`, `MD_x_rd`, `MD_x_rd_vld`) that is muxed onto the EX write-back and forwarding path.

## Interface
Parameters: none; the width is fixed at 32 bits.

- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `ID_md_vld`  in  1  — start request; the M-extension instruction is present in EX.
- `ID_md_op`  in  3  — funct3 encoding:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `ID_rd`  in  5  — destination register of the request.
- `OF_x_rs1`  in  32  — forwarded rs1 (multiplicand / dividend).
- `OF_x_rs2`  in  32  — forwarded rs2 (multiplier / divisor).
- `EX_flush`  in  1  — abort the current or incoming operation (branch / trap).
- `MD_busy`  out  1  — registered; the unit is occupied and upstream must stall.
- `MD_rd`  out  5  — registered destination of the result.
- `MD_x_rd`  out  32  — registered result.
- `MD_x_rd_vld`  out  1  — one-cycle result-valid pulse.

## Operation
- States: IDLE, MUL, DIV, DONE.
- **Accept:** IDLE ∧ `ID_md_vld` ∧ ¬`EX_flush`.
  - Latch the op, the rd, and both operands.
  - Go to MUL (op[2]=0) or DIV (op[2]=1).
  - In any other state, `ID_md_vld` is ignored; upstream holds the instruction while `MD_busy`=1.
- **Operand conditioning:**
  - rs1 is signed for MULH, MULHSU, DIV, REM.
  - rs2 is signed for MULH, DIV, REM.
  - Convert signed negative operands to magnitude (two's-complement negate).
  - Record sign_p = sa⊕sb (product/quotient sign) and sign_r = sa (remainder sign).
- **MUL state:** 32 iterations of unsigned shift-add on the magnitudes into a 64-bit accumulator.
  - A 6-bit counter runs 0..31.
  - After iteration 31, negate the 64-bit product if sign_p.
  - MUL returns product[31:0]; the other multiply ops return product[63:32].
- **DIV state:** 32 iterations of restoring division on the magnitudes.
  - Remainder register is 33 bits; quotient register is 32 bits.
  - Per iteration: shift in the next dividend bit MSB-first, trial-subtract the divisor, set the quotient bit when the result is non-negative.
  - Negate the quotient if sign_p; negate the remainder if sign_r.
- **Early-out cases.** These skip the iterations and go straight to DONE:
  - Divisor = 0: quotient = 0xFFFFFFFF; remainder = dividend. Applies to signed and unsigned ops.
  - Signed overflow, rs1 = 0x80000000 and rs2 = 0xFFFFFFFF (DIV/REM only): quotient = 0x80000000, remainder = 0.
- **DONE state:**
  - `MD_x_rd_vld` = 1 for exactly one cycle, with `MD_rd`/`MD_x_rd` valid.
  - Next state is IDLE.
  - When `MD_rd` = 0, `MD_x_rd_vld` = 0 and `MD_x_rd` = 0. This keeps x0 from ever being forwarded or written.
- **Flush:**
  - `EX_flush` has priority in every state: next state IDLE, counter cleared.
  - `MD_x_rd_vld` is combinationally masked to 0 in the flush cycle, including during DONE.
  - Accept + flush in the same cycle: no accept.
- **Reset:**
  - State IDLE, counter 0.
  - `MD_busy`=0, `MD_x_rd_vld`=0, `MD_rd`=0, `MD_x_rd`=0.
  - Reset overrides flush and accept; reset mid-operation discards the operation with no pulse.

## Timing
- Accept in cycle N.
- `MD_busy` is high from cycle N+1 through the DONE cycle inclusive, and low in IDLE.
- Normal path: iterations occupy N+1..N+32; DONE (`MD_x_rd_vld`=1) is in N+33.
- Early-out path: DONE is in N+1 (latency 1).
- `MD_busy` deasserts in the cycle after DONE. A new request can be accepted in that cycle (DONE+1), giving a back-to-back throughput of one op per 34 cycles.
- `MD_rd`/`MD_x_rd` hold their last values outside DONE. Consumers must qualify them with `MD_x_rd_vld`.
- `MD_busy` has no combinational path from inputs. The hazard unit forms stall = (`ID_md_vld` ∧ IDLE) ∨ `MD_busy`.

## Test plan
1. **Reset.** Assert `rst` for 2 cycles mid-DIV.
   - All outputs are 0, state is IDLE, and no `MD_x_rd_vld` pulse occurs afterwards.
2. **MUL and MULH.**
   - MUL with rs1=0xFFFFFFFE (−2), rs2=3, rd=5: at N+33, `MD_x_rd`=0xFFFFFFFA, `MD_rd`=5, with a single-cycle pulse.
   - MULH with 0x80000000 × 0x80000000: result 0x40000000.
   - MULHU with 0xFFFFFFFF × 0xFFFFFFFF: result 0xFFFFFFFE.
   - MULHSU with 0xFFFFFFFF × 0xFFFFFFFF: result 0xFFFFFFFF.
3. **Signed division.**
   - DIV −7/2: quotient 0xFFFFFFFD (−3).
   - REM −7/2: remainder 0xFFFFFFFF (−1).
   - DIVU 100/7: 14. REMU 100/7: 2.
   - All at N+33.
4. **Early-outs.** Each result arrives at N+1.
   - DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5.
   - DIV 0x80000000/−1 → 0x80000000; REM of the same → 0.
5. **Flush.**
   - `EX_flush` at N+10 of a DIV: IDLE at N+11, `MD_busy`=0, no pulse.
   - Flush in the DONE cycle: pulse masked.
   - Flush together with `ID_md_vld`: no accept.
6. **x0 destination and back-to-back ops.**
   - MUL with rd=0: `MD_busy` follows the full latency, and `MD_x_rd_vld` stays 0.
   - Second request asserted continuously: it is accepted exactly at DONE+1, and its own pulse arrives 33 cycles later.
